// File: rtl/gamepad_pkg.sv
// Shared types and bit map for the SNES gamepad reader.
// No logic here; one pure helper that turns the raw serial word into pressed flags.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        PH_HI,
        PH_LO,
        DONE
    } state_t;

    localparam int GP_BITS    = 16;
    localparam int GP_BUTTONS = 12;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // The pad pulls every line low when absent, so an all-zero word means "no pad".
    function automatic logic [GP_BUTTONS-1:0] pressed_flags(input logic [GP_BITS-1:0] raw);
        return (raw != '0) ? ~raw[GP_BUTTONS-1:0] : '0;
    endfunction

endpackage

// File: rtl/snes_gamepad_reader_sync2.sv
// Two-flop synchronizer for the asynchronous pad data pin.
// Latency 2 cycles; no flow control.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_gamepad_reader.sv
// SNES pad poller: latch, 16 clocked serial bits, publish pressed flags on o_valid.
// Latency 34*HALF_CYCLES+1 cycles from i_start; i_start outside IDLE is dropped.
module snes_gamepad_reader
    import gamepad_pkg::*;
#(
    parameter int HALF_CYCLES = 150
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_data,
    output logic                  o_latch,
    output logic                  o_pclk,
    output logic                  o_up,
    output logic                  o_down,
    output logic                  o_left,
    output logic                  o_right,
    output logic                  o_pause,
    output logic                  o_restart,
    output logic [GP_BUTTONS-1:0] o_buttons,
    output logic                  o_present,
    output logic                  o_valid,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(2 * HALF_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [3:0]           bit_idx;
    logic [3:0]           bit_nxt;
    logic                 capture;
    logic [GP_BITS-1:0]   shift_q;
    logic                 data_s;

    logic                 latch_nxt;
    logic                 pclk_nxt;
    logic                 busy_nxt;
    logic                 publish;

    logic                 latch_q;
    logic                 pclk_q;
    logic                 busy_q;
    logic                 valid_q;
    logic                 present_q;
    logic [GP_BUTTONS-1:0] btn_q;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_data),
        .q     (data_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (i_start) begin
                    state_nxt = LATCH;
                    bit_nxt   = '0;
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    state_nxt = PH_HI;
                    cnt_nxt   = '0;
                end
            end
            PH_HI: begin
                if (cnt == HALF_LAST) begin
                    capture   = 1'b1;
                    state_nxt = PH_LO;
                    cnt_nxt   = '0;
                end
            end
            PH_LO: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (bit_idx == 4'd15) begin
                        state_nxt = DONE;
                    end else begin
                        bit_nxt   = bit_idx + 4'd1;
                        state_nxt = PH_HI;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Pin levels are registered from the next state so they track the FSM without a lag.
        latch_nxt = (state_nxt == LATCH);
        pclk_nxt  = (state_nxt != PH_LO);
        busy_nxt  = (state_nxt != IDLE);
        publish   = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (capture) begin
            shift_q[bit_idx] <= data_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_q   <= 1'b0;
            pclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            btn_q     <= '0;
        end else begin
            latch_q <= latch_nxt;
            pclk_q  <= pclk_nxt;
            busy_q  <= busy_nxt;
            valid_q <= publish;
            if (publish) begin
                present_q <= (shift_q != '0);
                btn_q     <= pressed_flags(shift_q);
            end
        end
    end

    assign o_latch   = latch_q;
    assign o_pclk    = pclk_q;
    assign o_busy    = busy_q;
    assign o_valid   = valid_q;
    assign o_present = present_q;
    assign o_buttons = btn_q;
    assign o_up      = btn_q[BTN_UP];
    assign o_down    = btn_q[BTN_DOWN];
    assign o_left    = btn_q[BTN_LEFT];
    assign o_right   = btn_q[BTN_RIGHT];
    assign o_pause   = btn_q[BTN_START];
    assign o_restart = btn_q[BTN_SELECT];

endmodule

// File: tb/tb_snes_gamepad_reader.sv
// Directed bench for snes_gamepad_reader with a behavioural SNES pad on the pins.
module tb_snes_gamepad_reader;

    localparam int HC  = 4;
    localparam int LAT = 34 * HC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_data;
    logic        o_latch, o_pclk, o_up, o_down, o_left, o_right, o_pause, o_restart;
    logic [11:0] o_buttons;
    logic        o_present, o_valid, o_busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] pad_raw = 16'hFFFF;
    logic        pad_on  = 1'b1;
    int          pad_idx = 0;

    always #5 clk = ~clk;

    snes_gamepad_reader #(.HALF_CYCLES(HC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .i_data    (i_data),
        .o_latch   (o_latch),
        .o_pclk    (o_pclk),
        .o_up      (o_up),
        .o_down    (o_down),
        .o_left    (o_left),
        .o_right   (o_right),
        .o_pause   (o_pause),
        .o_restart (o_restart),
        .o_buttons (o_buttons),
        .o_present (o_present),
        .o_valid   (o_valid),
        .o_busy    (o_busy)
    );

    // Pad shift register: latch loads bit 0, each pclk rise advances one bit.
    always @(posedge o_latch or posedge o_pclk) begin
        if (o_latch) pad_idx = 0;
        else if (pad_idx < 16) pad_idx = pad_idx + 1;
    end

    always @* begin
        i_data = (pad_on && pad_idx < 16) ? pad_raw[pad_idx[3:0]] : 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pub(input string tag, input logic [11:0] eb, input logic ep);
        chk({tag, "_buttons"}, 32'(o_buttons), 32'(eb));
        chk({tag, "_present"}, 32'(o_present), 32'(ep));
        chk({tag, "_up"},      32'(o_up),      32'(eb[4]));
        chk({tag, "_down"},    32'(o_down),    32'(eb[5]));
        chk({tag, "_left"},    32'(o_left),    32'(eb[6]));
        chk({tag, "_right"},   32'(o_right),   32'(eb[7]));
        chk({tag, "_pause"},   32'(o_pause),   32'(eb[3]));
        chk({tag, "_restart"}, 32'(o_restart), 32'(eb[2]));
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Starts a poll and waits (bounded) for o_valid; published outputs must hold until then.
    task automatic run_poll(input string tag, input logic [15:0] raw, input logic on,
                            input logic [11:0] prev_btn);
        int lat;
        int moved;
        lat   = -1;
        moved = 0;
        pad_raw = raw;
        pad_on  = on;
        start_pulse();
        for (int m = 0; m < 200 && lat < 0; m++) begin
            if (o_valid) begin
                lat = m;
            end else begin
                if (o_buttons !== prev_btn) moved++;
                tick();
            end
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_hold"}, moved, 0);
    endtask

    initial begin
        int bad_latch, bad_pclk, bad_busy, bad_valid, n_valid;
        logic e_latch, e_pclk, e_busy, e_valid;

        // Reset state.
        repeat (3) tick();
        chk("rst_latch", 32'(o_latch), 0);
        chk("rst_pclk",  32'(o_pclk),  1);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy",  32'(o_busy),  0);
        check_pub("rst", 12'h000, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();

        // First poll with per-cycle pin timing; UP+START pressed.
        // Extra i_start pulses mid-transfer and in the DONE cycle must both be dropped.
        pad_raw = 16'hFFE7;
        pad_on  = 1'b1;
        bad_latch = 0; bad_pclk = 0; bad_busy = 0; bad_valid = 0; n_valid = 0;
        start_pulse();
        for (int m = 0; m <= 140; m++) begin
            e_latch = (m <= 7);
            e_busy  = (m <= LAT);
            e_valid = (m == LAT);
            e_pclk  = !(m >= 12 && m <= 135 && ((m - 12) % 8) < 4);
            if (o_latch !== e_latch) bad_latch++;
            if (o_pclk  !== e_pclk)  bad_pclk++;
            if (o_busy  !== e_busy)  bad_busy++;
            if (o_valid !== e_valid) bad_valid++;
            if (o_valid === 1'b1) n_valid++;
            if (m == LAT) check_pub("upstart", 12'h018, 1'b1);
            i_start = (m == 49 || m == LAT);
            tick();
        end
        i_start = 1'b0;
        chk("p1_latch_timing", bad_latch, 0);
        chk("p1_pclk_timing",  bad_pclk,  0);
        chk("p1_busy_timing",  bad_busy,  0);
        chk("p1_valid_timing", bad_valid, 0);
        chk("p1_valid_count",  n_valid,   1);
        chk("p1_idle_after",   32'(o_busy), 0);
        check_pub("hold", 12'h018, 1'b1);
        repeat (9) tick();

        // No pad: pin stays low.
        run_poll("nopad", 16'h0000, 1'b0, 12'h018);
        check_pub("nopad", 12'h000, 1'b0);
        tick();
        chk("nopad_valid_pulse", 32'(o_valid), 0);

        // Every exported button pressed; only the unexported bits 12-15 high.
        run_poll("all", 16'hF000, 1'b1, 12'h000);
        check_pub("all", 12'hFFF, 1'b1);
        tick();

        // LEFT then RIGHT: the swap happens exactly on the second o_valid.
        run_poll("left", 16'hFFBF, 1'b1, 12'hFFF);
        check_pub("left", 12'h040, 1'b1);
        tick();
        run_poll("right", 16'hFF7F, 1'b1, 12'h040);
        check_pub("right", 12'h080, 1'b1);
        tick();

        // Reset in the middle of a PH_LO phase.
        pad_raw = 16'hFFE7;
        start_pulse();
        repeat (68) tick();
        chk("mid_pclk_low", 32'(o_pclk), 0);
        rst_n = 1'b0;
        tick();
        chk("mrst_latch", 32'(o_latch), 0);
        chk("mrst_pclk",  32'(o_pclk),  1);
        chk("mrst_busy",  32'(o_busy),  0);
        chk("mrst_valid", 32'(o_valid), 0);
        check_pub("mrst", 12'h000, 1'b0);
        rst_n = 1'b1;
        n_valid = 0;
        for (int m = 0; m < 160; m++) begin
            if (o_valid === 1'b1) n_valid++;
            tick();
        end
        chk("mrst_no_valid", n_valid, 0);

        // Recovery after reset: B pressed.
        run_poll("b", 16'hFFFE, 1'b1, 12'h000);
        check_pub("b", 12'h001, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
